// File: rtl/mips_id_ctrl_exmem.sv
// MIPS ID-stage instruction decode with main/ALU control, plus the EX/MEM pipeline register.
// Decode and control are purely combinational; EX/MEM captures EX results on every rising edge.
module mips_id_ctrl_exmem (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [5:0]  op,
  output logic [5:0]  fuc,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic        branch,
  output logic        jump,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        reg_wr,
  output logic        mem_wr,
  output logic        ext_op,
  output logic        r_type,
  output logic [2:0]  alu_ctr,
  input  logic [1:0]  i_WB,
  input  logic        i_M,
  input  logic        i_zero,
  input  logic        i_overflow,
  input  logic [31:0] i_result,
  input  logic [31:0] i_BusB,
  input  logic [4:0]  i_Rw,
  output logic [1:0]  o_WB,
  output logic        o_M,
  output logic        o_zero,
  output logic        o_overflow,
  output logic [31:0] o_result,
  output logic [31:0] o_BusB,
  output logic [4:0]  o_Rw
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;

  localparam logic [2:0] AluAddu = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluOr   = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;
  localparam logic [2:0] AluSubu = 3'b100;
  localparam logic [2:0] AluSub  = 3'b101;
  localparam logic [2:0] AluSltu = 3'b110;
  localparam logic [2:0] AluSlt  = 3'b111;

  assign op     = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign fuc    = instruction[5:0];
  assign imm16  = instruction[15:0];
  assign target = instruction[25:0];

  logic       fn_valid;
  logic [2:0] fn_alu;

  always_comb begin
    fn_valid = 1'b1;
    fn_alu   = AluAddu;
    case (fuc)
      FnAdd:   fn_alu = AluAdd;
      FnAddu:  fn_alu = AluAddu;
      FnSub:   fn_alu = AluSub;
      FnSubu:  fn_alu = AluSubu;
      FnAnd:   fn_alu = AluAnd;
      FnOr:    fn_alu = AluOr;
      FnSlt:   fn_alu = AluSlt;
      FnSltu:  fn_alu = AluSltu;
      default: fn_valid = 1'b0;
    endcase
  end

  always_comb begin
    branch     = 1'b0;
    jump       = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ext_op     = 1'b0;
    alu_ctr    = AluAddu;
    // r_type flags the opcode class even when the function code is unsupported
    r_type     = (op == OpRtype);
    case (op)
      OpRtype: begin
        if (fn_valid) begin
          reg_dst = 1'b1;
          reg_wr  = 1'b1;
          alu_ctr = fn_alu;
        end
      end
      OpOri: begin
        alu_src = 1'b1;
        reg_wr  = 1'b1;
        alu_ctr = AluOr;
      end
      OpAddiu: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        reg_wr  = 1'b1;
      end
      OpLw: begin
        alu_src    = 1'b1;
        ext_op     = 1'b1;
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
      end
      OpSw: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        mem_wr  = 1'b1;
      end
      OpBeq: begin
        branch  = 1'b1;
        alu_ctr = AluSubu;
      end
      OpJ: begin
        jump = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset inserts a bubble: no register or memory write leaves this stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_WB       <= '0;
      o_M        <= 1'b0;
      o_zero     <= 1'b0;
      o_overflow <= 1'b0;
      o_result   <= '0;
      o_BusB     <= '0;
      o_Rw       <= '0;
    end else begin
      o_WB       <= i_WB;
      o_M        <= i_M;
      o_zero     <= i_zero;
      o_overflow <= i_overflow;
      o_result   <= i_result;
      o_BusB     <= i_BusB;
      o_Rw       <= i_Rw;
    end
  end

endmodule

// File: tb/tb_mips_id_ctrl_exmem.sv
// Self-checking bench for mips_id_ctrl_exmem: directed decode vectors, randomized decode
// against an opcode lookup table, and EX/MEM latency/reset sequences.
module tb_mips_id_ctrl_exmem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [5:0]  op, fuc;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic        branch, jump, reg_dst, alu_src, mem_to_reg, reg_wr, mem_wr, ext_op, r_type;
  logic [2:0]  alu_ctr;
  logic [1:0]  i_WB, o_WB;
  logic        i_M, i_zero, i_overflow, o_M, o_zero, o_overflow;
  logic [31:0] i_result, i_BusB, o_result, o_BusB;
  logic [4:0]  i_Rw, o_Rw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_id_ctrl_exmem dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .op(op), .fuc(fuc), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
    .target(target), .branch(branch), .jump(jump), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .mem_wr(mem_wr), .ext_op(ext_op),
    .r_type(r_type), .alu_ctr(alu_ctr),
    .i_WB(i_WB), .i_M(i_M), .i_zero(i_zero), .i_overflow(i_overflow),
    .i_result(i_result), .i_BusB(i_BusB), .i_Rw(i_Rw),
    .o_WB(o_WB), .o_M(o_M), .o_zero(o_zero), .o_overflow(o_overflow),
    .o_result(o_result), .o_BusB(o_BusB), .o_Rw(o_Rw)
  );

  // Control word: {branch,jump,reg_dst,alu_src,mem_to_reg,reg_wr,mem_wr,ext_op,r_type,alu_ctr}
  logic [11:0] act_ctrl;
  assign act_ctrl = {branch, jump, reg_dst, alu_src, mem_to_reg, reg_wr, mem_wr, ext_op,
                     r_type, alu_ctr};

  logic [73:0] act_exmem;
  assign act_exmem = {o_WB, o_M, o_zero, o_overflow, o_result, o_BusB, o_Rw};

  typedef struct {
    logic [31:0] instr;
    logic [11:0] ctrl;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fuc;
    logic        use_fuc;
    logic [11:0] ctrl;
  } ref_t;

  vec_t vecs[12];
  ref_t ref_tab[14];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: look the instruction up in a table of supported encodings.
  function automatic logic [11:0] ref_ctrl(input logic [31:0] ins);
    logic [5:0] o;
    logic [5:0] f;
    o = ins[31:26];
    f = ins[5:0];
    for (int i = 0; i < 14; i++)
      if (ref_tab[i].op == o && (!ref_tab[i].use_fuc || ref_tab[i].fuc == f))
        return ref_tab[i].ctrl;
    return (o == 6'd0) ? 12'h008 : 12'h000;
  endfunction

  logic [5:0]  ops[8];
  logic [5:0]  fns[9];
  logic [31:0] ins;
  logic [73:0] exp_exmem;

  initial begin
    ref_tab[0]  = '{6'h00, 6'h20, 1'b1, 12'h249};
    ref_tab[1]  = '{6'h00, 6'h21, 1'b1, 12'h248};
    ref_tab[2]  = '{6'h00, 6'h22, 1'b1, 12'h24D};
    ref_tab[3]  = '{6'h00, 6'h23, 1'b1, 12'h24C};
    ref_tab[4]  = '{6'h00, 6'h24, 1'b1, 12'h24B};
    ref_tab[5]  = '{6'h00, 6'h25, 1'b1, 12'h24A};
    ref_tab[6]  = '{6'h00, 6'h2A, 1'b1, 12'h24F};
    ref_tab[7]  = '{6'h00, 6'h2B, 1'b1, 12'h24E};
    ref_tab[8]  = '{6'h0D, 6'h00, 1'b0, 12'h142};
    ref_tab[9]  = '{6'h09, 6'h00, 1'b0, 12'h150};
    ref_tab[10] = '{6'h23, 6'h00, 1'b0, 12'h1D0};
    ref_tab[11] = '{6'h2B, 6'h00, 1'b0, 12'h130};
    ref_tab[12] = '{6'h04, 6'h00, 1'b0, 12'h804};
    ref_tab[13] = '{6'h02, 6'h00, 1'b0, 12'h400};

    vecs[0]  = '{32'h00221820, 12'h249};  // add
    vecs[1]  = '{32'h8C430004, 12'h1D0};  // lw
    vecs[2]  = '{32'h1022FFFE, 12'h804};  // beq
    vecs[3]  = '{32'h08000010, 12'h400};  // j
    vecs[4]  = '{32'h3443FFFF, 12'h142};  // ori
    vecs[5]  = '{32'hFC000000, 12'h000};  // unlisted op
    vecs[6]  = '{32'h00000000, 12'h008};  // sll 0 (unlisted fuc, still r_type)
    vecs[7]  = '{32'hAC430008, 12'h130};  // sw
    vecs[8]  = '{32'h24420001, 12'h150};  // addiu
    vecs[9]  = '{32'h0043182A, 12'h24F};  // slt
    vecs[10] = '{32'h00431823, 12'h24C};  // subu
    vecs[11] = '{32'h0043183F, 12'h008};  // unlisted fuc

    ops = '{6'h00, 6'h0D, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h08};

    rst = 1'b1;
    instruction = '0;
    i_WB = 2'b11; i_M = 1'b1; i_zero = 1'b1; i_overflow = 1'b1;
    i_result = 32'h12345678; i_BusB = 32'h9ABCDEF0; i_Rw = 5'd31;
    @(posedge clk); #1;
    check("reset_state", {6'd0, act_exmem}, 80'd0);

    for (int i = 0; i < 12; i++) begin
      instruction = vecs[i].instr;
      #1;
      check($sformatf("vec%0d_ctrl", i), {68'd0, act_ctrl}, {68'd0, vecs[i].ctrl});
    end

    instruction = 32'h00221820; #1;
    check("add_fields", {49'd0, rs, rt, rd, fuc, shamt},
          {49'd0, 5'd1, 5'd2, 5'd3, 6'h20, 5'd0});
    instruction = 32'h8C430004; #1;
    check("lw_fields", {54'd0, rs, rt, imm16}, {54'd0, 5'd2, 5'd3, 16'h0004});
    instruction = 32'h08000010; #1;
    check("j_target", {54'd0, target}, {54'd0, 26'h0000010});
    check("j_op", {74'd0, op}, {74'd0, 6'h02});

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:26] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) ins[5:0] = fns[$urandom_range(0, 8)];
      instruction = ins;
      #1;
      check("rand_ctrl", {68'd0, act_ctrl}, {68'd0, ref_ctrl(ins)});
      check("rand_fields", {48'd0, op, rs, rt, rd, shamt, fuc},
            {48'd0, 6'((ins >> 26) & 32'h3F), 5'((ins >> 21) & 32'h1F),
             5'((ins >> 16) & 32'h1F), 5'((ins >> 11) & 32'h1F),
             5'((ins >> 6) & 32'h1F), 6'(ins & 32'h3F)});
    end

    // Capture latency: unchanged before the edge, equal after it.
    @(negedge clk);
    rst = 1'b0;
    i_WB = 2'b01; i_M = 1'b0; i_zero = 1'b0; i_overflow = 1'b0;
    i_result = 32'hDEADBEEF; i_BusB = 32'h0; i_Rw = 5'd7;
    #1;
    check("exmem_before_edge", {6'd0, act_exmem}, 80'd0);
    @(posedge clk); #1;
    check("exmem_after_edge", {6'd0, act_exmem},
          {6'd0, 2'b01, 3'b000, 32'hDEADBEEF, 32'h0, 5'd7});

    // Reset dominates nonzero inputs; capture resumes on the edge after release.
    @(negedge clk);
    rst = 1'b1;
    i_WB = 2'b11; i_M = 1'b1; i_zero = 1'b1; i_overflow = 1'b1;
    i_result = 32'hCAFEF00D; i_BusB = 32'h55AA55AA; i_Rw = 5'd19;
    @(posedge clk); #1;
    check("exmem_rst_clears", {6'd0, act_exmem}, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("exmem_rst_release_hold", {6'd0, act_exmem}, 80'd0);
    @(posedge clk); #1;
    check("exmem_resume", {6'd0, act_exmem},
          {6'd0, 2'b11, 3'b111, 32'hCAFEF00D, 32'h55AA55AA, 5'd19});

    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 7) == 0);
      i_WB = 2'($urandom); i_M = 1'($urandom); i_zero = 1'($urandom);
      i_overflow = 1'($urandom); i_result = $urandom; i_BusB = $urandom;
      i_Rw = 5'($urandom);
      exp_exmem = rst ? 74'd0 : {i_WB, i_M, i_zero, i_overflow, i_result, i_BusB, i_Rw};
      @(posedge clk); #1;
      check("exmem_rand", {6'd0, act_exmem}, {6'd0, exp_exmem});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
